// File: rtl/sound_sample_decoder.sv
// sound_sample_decoder
//   Integrates a 1-bit audio stream over each video line and turns the
//   per-line count into an 8-bit sample. The samples are queued in a small FIFO.
//   A line boundary is the cycle with x==0. The first, partial line after
//   reset is discarded.
//
// Ports
//   clk          pixel clock (rising edge)
//   reset        asynchronous reset, active low
//   sound        1-bit audio stream, one bit per pixel clock
//   x, y         horizontal / vertical pixel counters
//   sample_data  FIFO head sample (0 while empty)
//   sample_first head sample was taken on line y==0
//   sample_valid FIFO non-empty
//   sample_ready consumer accepts head (pop on valid & ready)
//   ovf_clr      single-cycle overflow clear
//   overflow     sticky: a completed sample was dropped on a full FIFO
//   fill         current FIFO occupancy
module sound_sample_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int SHIFT      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sound,
    input  logic [9:0]                    x,
    input  logic [9:0]                    y,
    output logic [7:0]                    sample_data,
    output logic                          sample_first,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    input  logic                          ovf_clr,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {SYNC, ACCUM} state_t;

    state_t        state_q, state_d;
    logic [9:0]    acc_q, acc_d;
    logic [9:0]    line_y_q, line_y_d;
    logic [10:0]   acc_sum;
    logic          line_start;
    logic          push;
    logic [8:0]    push_word;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full, pop, wr_en, drop;
    logic [8:0]    head;

    assign line_start = (x == '0);
    assign push       = (state_q == ACCUM) && line_start;
    assign acc_sum    = {1'b0, acc_q} + {10'd0, sound};
    assign push_word  = {(line_y_q == '0), 8'(acc_q >> SHIFT)};

    // Line accumulator FSM
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        line_y_d = line_y_q;
        case (state_q)
            SYNC: begin
                if (line_start) begin
                    state_d  = ACCUM;
                    acc_d    = {9'd0, sound};
                    line_y_d = y;
                end
            end
            ACCUM: begin
                if (line_start) begin
                    acc_d    = {9'd0, sound};
                    line_y_d = y;
                end else begin
                    // saturate at 1023 instead of wrapping
                    acc_d = acc_sum[10] ? '1 : acc_sum[9:0];
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // FIFO control: a push on a full FIFO survives only if a pop frees a slot
    // in the same cycle; otherwise the sample is dropped and flagged.
    assign sample_valid = (count_q != '0);
    assign full         = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop          = sample_valid && sample_ready;
    assign wr_en        = push && (!full || pop);
    assign drop         = push && full && !pop;

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // a new drop wins over a coincident clear
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= SYNC;
            acc_q    <= '0;
            line_y_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            line_y_q <= line_y_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // storage needs no reset: outputs are masked by sample_valid
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= push_word;
    end

    assign head         = mem[rd_ptr_q];
    assign sample_data  = sample_valid ? head[7:0] : '0;
    assign sample_first = sample_valid ? head[8]   : 1'b0;
    assign overflow     = ovf_q;
    assign fill         = count_q;

endmodule

// File: tb/tb_sound_sample_decoder.sv
module tb_sound_sample_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       sound;
    logic [9:0] x, y;
    logic [7:0] sample_data;
    logic       sample_first, sample_valid, sample_ready, ovf_clr, overflow;
    logic [2:0] fill;

    sound_sample_decoder #(.FIFO_DEPTH(DEPTH), .SHIFT(2)) dut (
        .clk(clk), .reset(reset), .sound(sound), .x(x), .y(y),
        .sample_data(sample_data), .sample_first(sample_first),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .ovf_clr(ovf_clr), .overflow(overflow), .fill(fill)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [8:0] q[$];
    bit         maccum;
    int         macc;
    int         my;
    bit         movf;
    int         pops;
    logic [7:0] last_data;
    logic       last_first;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, check outputs, advance model.
    task automatic step(input bit rst, input bit snd, input int xv, input int yv,
                        input bit rdy, input bit clr);
        bit         do_pop, do_push;
        int         sz;
        logic [8:0] word;
        reset = rst; sound = snd; x = 10'(xv); y = 10'(yv);
        sample_ready = rdy; ovf_clr = clr;
        if (!rst) begin
            q.delete(); maccum = 0; macc = 0; my = 0; movf = 0;
        end
        #1;
        sz = q.size();
        chk("valid", {31'd0, sample_valid}, {31'd0, sz != 0});
        chk("fill", {29'd0, fill}, sz);
        chk("overflow", {31'd0, overflow}, {31'd0, movf});
        if (sz != 0) begin
            chk("head_data", {24'd0, sample_data}, {24'd0, q[0][7:0]});
            chk("head_first", {31'd0, sample_first}, {31'd0, q[0][8]});
        end
        if (rst) begin
            do_pop  = (sz != 0) && rdy;
            do_push = maccum && (xv == 0);
            word    = {(my == 0), 8'(macc >> 2)};
            if (do_pop) begin
                last_data  = q[0][7:0];
                last_first = q[0][8];
                pops++;
                void'(q.pop_front());
            end
            if (clr) movf = 0;
            if (do_push) begin
                if (sz == DEPTH && !do_pop) movf = 1;
                else q.push_back(word);
            end
            if (xv == 0) begin
                maccum = 1; macc = int'(snd); my = yv;
            end else if (maccum) begin
                macc = (macc + int'(snd) > 1023) ? 1023 : macc + int'(snd);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // rmode: 0 ready low, 1 ready high, 2 ready only on x==0. clr_x<0: no clear.
    task automatic run_line(input int yv, input int len, input int ones,
                            input int rmode, input int clr_x);
        for (int i = 0; i < len; i++)
            step(1'b1, i < ones, i, yv,
                 (rmode == 1) || (rmode == 2 && i == 0), i == clr_x);
    endtask

    initial begin
        reset = 1'b0; sound = 1'b0; x = '0; y = '0;
        sample_ready = 1'b0; ovf_clr = 1'b0;
        pops = 0; last_data = '0; last_first = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_valid", {31'd0, sample_valid}, 0);
        chk("rst_fill", {29'd0, fill}, 0);
        chk("rst_data", {24'd0, sample_data}, 0);
        chk("rst_first", {31'd0, sample_first}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
        @(negedge clk);

        // reset released mid-line at x=300: partial line must not produce a sample
        for (int i = 0; i < 800; i++) step(i >= 300, 1'b1, i, 0, 1'b1, 1'b0);
        run_line(1, 800, 400, 1, -1);
        chk("no_partial_sample", pops, 0);
        run_line(2, 800, 400, 1, -1);
        chk("pops_line2", pops, 1);
        chk("sample_100_a", {24'd0, last_data}, 100);
        run_line(3, 800, 400, 1, -1);
        chk("sample_100_b", {24'd0, last_data}, 100);

        // ready held low for 6 lines: FIFO fills, later samples dropped
        for (int k = 0; k < 6; k++) run_line(4 + k, 800, 40 * (k + 1), 0, -1);
        chk("full_fill", {29'd0, fill}, DEPTH);
        chk("full_ovf", {31'd0, overflow}, 1);
        chk("full_head", {24'd0, sample_data}, 100);
        run_line(10, 800, 0, 0, 5);
        chk("ovf_cleared", {31'd0, overflow}, 0);

        // push and pop together on a full FIFO
        run_line(11, 800, 800, 2, -1);
        chk("pushpop_fill", {29'd0, fill}, DEPTH);
        chk("pushpop_ovf", {31'd0, overflow}, 0);
        chk("pushpop_head", {24'd0, sample_data}, 10);
        run_line(12, 800, 0, 1, -1);
        chk("sample_200", {24'd0, last_data}, 200);
        chk("drained", {29'd0, fill}, 0);

        // saturation: x stays away from 0 for 1100 clocks
        step(1'b1, 1'b1, 0, 13, 1'b1, 1'b0);
        for (int i = 0; i < 1100; i++) step(1'b1, 1'b1, 1 + (i % 799), 13, 1'b1, 1'b0);
        step(1'b1, 1'b0, 0, 14, 1'b1, 1'b0);
        chk("sat_valid", {31'd0, sample_valid}, 1);
        chk("sat_255", {24'd0, sample_data}, 255);

        // line y==0 flag
        run_line(524, 800, 800, 1, -1);
        run_line(0, 800, 800, 1, -1);
        chk("first_524_data", {24'd0, last_data}, 200);
        chk("first_524", {31'd0, last_first}, 0);
        run_line(1, 800, 800, 1, -1);
        chk("first_0", {31'd0, last_first}, 1);
        run_line(2, 800, 0, 1, -1);
        chk("first_1", {31'd0, last_first}, 0);

        // reset asserted with a full FIFO
        for (int k = 0; k < 6; k++) run_line(3 + k, 10, 10, 0, -1);
        chk("pre_rst_fill", {29'd0, fill}, DEPTH);
        chk("pre_rst_ovf", {31'd0, overflow}, 1);
        reset = 1'b0;
        q.delete(); maccum = 0; macc = 0; my = 0; movf = 0;
        #1;
        chk("async_rst_valid", {31'd0, sample_valid}, 0);
        chk("async_rst_fill", {29'd0, fill}, 0);
        chk("async_rst_data", {24'd0, sample_data}, 0);
        chk("async_rst_ovf", {31'd0, overflow}, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, i, 9, 1'b1, 1'b0);
        pops = 0;
        for (int i = 5; i < 10; i++) step(1'b1, 1'b1, i, 9, 1'b1, 1'b0);
        run_line(10, 10, 10, 1, -1);
        chk("no_partial_after_rst", pops, 0);
        run_line(11, 10, 10, 1, -1);
        chk("short_line_sample", {24'd0, last_data}, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sound_sample_decoder.md
SOUND_SAMPLE_DECODER -- requirements
Module: sound_sample_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, means sample FIFO entries; the value shall be a power of two, minimum 2.
REQ-002 Parameter SHIFT, default 2, means right-shift applied to the 10-bit line count to form the 8-bit sample.
REQ-003 Port clk, input, 1 bit, is the pixel clock; all state shall be on its rising edge.
REQ-004 Port reset, input, 1 bit, is an asynchronous active-low reset: 0 resets, 1 runs.
REQ-005 Port sound, input, 1 bit, is the 1-bit audio stream from the audio unit, one bit per pixel clock.
REQ-006 Port x, input, 10 bits, is the current horizontal pixel counter.
REQ-007 Port y, input, 10 bits, is the current vertical line counter.
REQ-008 Port sample_data, output, 8 bits, is the FIFO head sample.
REQ-009 Port sample_first, output, 1 bit, is high when the head sample was taken on line y==0.
REQ-010 Port sample_valid, output, 1 bit, means the FIFO is non-empty.
REQ-011 Port sample_ready, input, 1 bit, means the consumer accepts the head; a pop shall occur on a cycle with valid&ready.
REQ-012 Port ovf_clr, input, 1 bit, is a single-cycle clear for overflow.
REQ-013 Port overflow, output, 1 bit, is a sticky flag meaning a completed sample was dropped.
REQ-014 Port fill, output, clog2(FIFO_DEPTH)+1 bits, is the current FIFO occupancy.

Function
REQ-015 The FSM shall have two states, SYNC and ACCUM; reset enters SYNC.
REQ-016 In SYNC, the block shall ignore sound until a cycle with x==0, then go to ACCUM with acc loaded with sound and line_y latched from y; the partial first line shall be discarded.
REQ-017 In ACCUM on a cycle with x!=0, acc shall become acc+sound and saturate at 1023 (no wrap).
REQ-018 In ACCUM on a cycle with x==0, the block shall push {line_y==0, acc>>SHIFT truncated to 8 bits}, reload acc with sound, and latch line_y from y, all in the same cycle.
REQ-019 Push-to-visible latency shall be 1 cycle: a push into an empty FIFO makes sample_valid=1 and sample_data valid immediately after that clock edge.
REQ-020 FIFO ordering shall be strict FIFO; sample_data and sample_first shall hold stable while valid&!ready.
REQ-021 When the FIFO is full and a push occurs with no pop, the new sample shall be dropped, FIFO contents kept unchanged, and overflow set to 1.
REQ-022 When the FIFO is full and push and pop occur in the same cycle, both shall take effect, fill shall stay FIFO_DEPTH, and overflow shall not be set.
REQ-023 When the FIFO is empty and push and pop occur in the same cycle, the pop shall be ignored (valid was 0) and the push shall take effect.
REQ-024 A pop when empty shall be a no-op; fill shall never underflow.
REQ-025 When ovf_clr and a new drop coincide, overflow shall end the cycle at 1.
REQ-026 fill shall equal the number of stored entries every cycle, in the range 0..FIFO_DEPTH.
REQ-027 With SHIFT=2, an 800-clock line of all-ones shall give sample 200, and a saturated count of 1023 shall give 255.

Reset
REQ-028 When reset is 0, the block shall asynchronously force state=SYNC, acc=0, line_y=0, FIFO empty (fill=0), sample_valid=0, sample_data=0, sample_first=0 and overflow=0.
REQ-029 Reset deassertion mid-line shall restart in SYNC; no sample from the interrupted line shall ever be pushed.
REQ-030 Reset asserted with a full FIFO shall leave all entries discarded, and sample_valid shall be 0 in the same cycle.

Verification
REQ-031 The bench shall run 800-clock lines with x sweeping 0..799, sound=1 for x<400, ready=1 -> each sample shall be 100, with sample_valid pulsing 1 cycle after x==0.
REQ-032 The bench shall release reset at x=300 -> the first pushed sample shall be from the next full line, and no partial-line sample shall appear.
REQ-033 The bench shall hold ready=0 for 6 lines with FIFO_DEPTH=4 -> fill shall be 4, overflow=1, and the head shall be the first line's sample; then pulse ovf_clr -> overflow=0.
REQ-034 With the FIFO full, the bench shall set ready=1 on the x==0 cycle -> fill shall stay 4, overflow shall stay 0, and the oldest sample shall be replaced at the tail in order.
REQ-035 The bench shall drive sound=1 constantly with x never returning to 0 for 1100 clocks, then x=0 -> the pushed sample shall be 255 (acc saturated at 1023).
REQ-036 The bench shall run lines y=524, 0, 1 -> sample_first shall be 1 only for the sample of line y==0.
